c1_bus_arbiter: RTL and testbench

// - Shares one C1 bus (cache-side port: address/data/command) between two requesters, e.g. CPU core and DMA/prefetch.
// - Each requester has a unidirectional valid/ready request and response interface. The block sequences the full
//   C1 transaction: 2 address phases, bus release, wait for C1_RESPONSE, read-data capture, timeout.
// - Sits between the requesters and the L1 cache; it is the only driver of the requester side of the C1 bus.

---
 rtl/c1_pkg.sv | 43 ++++
 rtl/c1_rr_grant.sv | 20 ++
 rtl/c1_bus_arbiter.sv | 156 +++++++++++++++
 tb/tb_c1_bus_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/c1_pkg.sv
// C1 bus command codes, arbiter FSM states and default bus geometry shared by
// the C1 arbiter and its round-robin grant helper.
package c1_pkg;

  localparam int C1_MEM_ADDR_SIZE     = 19;
  localparam int C1_CACHE_OFFSET_SIZE = 4;
  localparam int C1_BUS_SIZE          = 16;
  localparam int C1_TIMEOUT_CYCLES    = 1023;

  // Code 7 is WRITE32 when a requester drives it and RESPONSE when the cache
  // drives it, so on the request side only NOP is left over as a reject code.
  localparam logic [2:0] C1_NOP      = 3'd0;
  localparam logic [2:0] C1_READ8    = 3'd1;
  localparam logic [2:0] C1_READ16   = 3'd2;
  localparam logic [2:0] C1_READ32   = 3'd3;
  localparam logic [2:0] C1_INV_LINE = 3'd4;
  localparam logic [2:0] C1_WRITE8   = 3'd5;
  localparam logic [2:0] C1_WRITE16  = 3'd6;
  localparam logic [2:0] C1_WRITE32  = 3'd7;
  localparam logic [2:0] C1_RESPONSE = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR1,
    ST_ADDR2,
    ST_WAIT,
    ST_RD_HI,
    ST_DONE
  } c1_arb_state_t;

  function automatic logic c1_is_read(input logic [2:0] cmd);
    return (cmd == C1_READ8) || (cmd == C1_READ16) || (cmd == C1_READ32);
  endfunction

  function automatic logic c1_is_write(input logic [2:0] cmd);
    return (cmd == C1_WRITE8) || (cmd == C1_WRITE16) || (cmd == C1_WRITE32);
  endfunction

  function automatic logic c1_is_legal(input logic [2:0] cmd);
    return c1_is_read(cmd) || c1_is_write(cmd) || (cmd == C1_INV_LINE);
  endfunction

endpackage

// File: rtl/c1_rr_grant.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the one
// that did not win last time.
module c1_rr_grant (
  input  logic [1:0] req_valid,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_idx
);

  always_comb begin
    grant_valid = |req_valid;
    grant_idx   = 1'b0;
    case (req_valid)
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = ~last_grant;
      default: grant_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/c1_bus_arbiter.sv
// Shares the C1 cache port between two valid/ready requesters and sequences
// the full C1 transaction: two address phases, bus release, response, timeout.
module c1_bus_arbiter import c1_pkg::*; #(
  parameter int MEM_ADDR_SIZE     = C1_MEM_ADDR_SIZE,
  parameter int CACHE_OFFSET_SIZE = C1_CACHE_OFFSET_SIZE,
  parameter int BUS_SIZE          = C1_BUS_SIZE,
  parameter int TIMEOUT_CYCLES    = C1_TIMEOUT_CYCLES
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [1:0]                                    req_valid,
  input  logic [1:0][2:0]                               req_cmd,
  input  logic [1:0][MEM_ADDR_SIZE-1:0]                 req_addr,
  input  logic [1:0][2*BUS_SIZE-1:0]                    req_wdata,
  output logic [1:0]                                    req_ready,
  output logic [1:0]                                    rsp_valid,
  output logic [2*BUS_SIZE-1:0]                         rsp_rdata,
  output logic                                          rsp_err,
  output logic [MEM_ADDR_SIZE-CACHE_OFFSET_SIZE-1:0]    c1_addr,
  inout  wire  [BUS_SIZE-1:0]                           c1_data,
  inout  wire  [2:0]                                    c1_cmd
);

  localparam int AW    = MEM_ADDR_SIZE - CACHE_OFFSET_SIZE;
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  c1_arb_state_t             state, state_nxt;
  logic [2:0]                cmd_q;
  logic [MEM_ADDR_SIZE-1:0]  addr_q;
  logic [2*BUS_SIZE-1:0]     wdata_q;
  logic                      owner_q;
  logic                      last_grant;
  logic [CNT_W-1:0]          wait_cnt;

  logic                      gnt_vld;
  logic                      gnt_idx;
  logic                      rsp_seen;
  logic                      timed_out;

  logic                      addr_oe, data_oe, cmd_oe;
  logic [AW-1:0]             addr_o;
  logic [BUS_SIZE-1:0]       data_o;

  c1_rr_grant u_rr_grant (
    .req_valid   (req_valid),
    .last_grant  (last_grant),
    .grant_valid (gnt_vld),
    .grant_idx   (gnt_idx)
  );

  assign rsp_seen  = (c1_cmd == C1_RESPONSE);
  // The exit fires on the last legal count, so the counter never wraps.
  assign timed_out = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = '0;
    case (state)
      ST_IDLE: begin
        if (gnt_vld) begin
          req_ready[gnt_idx] = 1'b1;
          state_nxt = c1_is_legal(req_cmd[gnt_idx]) ? ST_ADDR1 : ST_DONE;
        end
      end
      ST_ADDR1: state_nxt = ST_ADDR2;
      ST_ADDR2: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (rsp_seen)
          state_nxt = (cmd_q == C1_READ32) ? ST_RD_HI : ST_DONE;
        else if (timed_out)
          state_nxt = ST_DONE;
      end
      ST_RD_HI: state_nxt = ST_DONE;
      ST_DONE: begin
        rsp_valid[owner_q] = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Bus drive is decoded from the registered state only, so a reset edge
  // releases every C1 line in the very next cycle.
  always_comb begin
    addr_oe = 1'b0;
    cmd_oe  = 1'b0;
    data_oe = 1'b0;
    addr_o  = '0;
    data_o  = wdata_q[BUS_SIZE-1:0];
    case (state)
      ST_ADDR1: begin
        addr_oe = 1'b1;
        cmd_oe  = 1'b1;
        addr_o  = addr_q[MEM_ADDR_SIZE-1:CACHE_OFFSET_SIZE];
        data_oe = c1_is_write(cmd_q);
      end
      ST_ADDR2, ST_WAIT: begin
        addr_oe = (state == ST_ADDR2);
        cmd_oe  = (state == ST_ADDR2);
        addr_o  = AW'(addr_q[CACHE_OFFSET_SIZE-1:0]);
        data_oe = c1_is_write(cmd_q);
        if (cmd_q == C1_WRITE32)
          data_o = wdata_q[2*BUS_SIZE-1:BUS_SIZE];
      end
      default: ;
    endcase
  end

  assign c1_addr = addr_oe ? addr_o : 'z;
  assign c1_data = data_oe ? data_o : 'z;
  assign c1_cmd  = cmd_oe  ? cmd_q  : 'z;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cmd_q      <= C1_NOP;
      addr_q     <= '0;
      wdata_q    <= '0;
      owner_q    <= 1'b0;
      last_grant <= 1'b1;
      wait_cnt   <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (gnt_vld) begin
            owner_q    <= gnt_idx;
            last_grant <= gnt_idx;
            cmd_q      <= req_cmd[gnt_idx];
            addr_q     <= req_addr[gnt_idx];
            wdata_q    <= req_wdata[gnt_idx];
            rsp_rdata  <= '0;
            rsp_err    <= ~c1_is_legal(req_cmd[gnt_idx]);
          end
        end
        ST_ADDR2: wait_cnt <= '0;
        ST_WAIT: begin
          if (rsp_seen) begin
            if (c1_is_read(cmd_q))
              rsp_rdata[BUS_SIZE-1:0] <= c1_data;
          end else if (timed_out) begin
            rsp_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_RD_HI: rsp_rdata[2*BUS_SIZE-1:BUS_SIZE] <= c1_data;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_c1_bus_arbiter.sv
// Scoreboarded bench for c1_bus_arbiter: a cache model answers on the C1 bus,
// expected completions are queued at grant and matched on rsp_valid.
module tb_c1_bus_arbiter;
  import c1_pkg::*;

  localparam int AS = 19;
  localparam int OS = 4;
  localparam int BS = 16;
  localparam int TO = 8;
  localparam int AW = AS - OS;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [1:0]            req_valid;
  logic [1:0][2:0]       req_cmd;
  logic [1:0][AS-1:0]    req_addr;
  logic [1:0][2*BS-1:0]  req_wdata;
  logic [1:0]            req_ready;
  logic [1:0]            rsp_valid;
  logic [2*BS-1:0]       rsp_rdata;
  logic                  rsp_err;

  // Pulls make a released line observable: addr/data float high, cmd low.
  tri1  [AW-1:0]         c1_addr;
  tri1  [BS-1:0]         c1_data;
  tri0  [2:0]            c1_cmd;

  logic                  cmd_oe, data_oe;
  logic [2:0]            cmd_drv;
  logic [BS-1:0]         data_drv;

  assign c1_cmd  = cmd_oe  ? cmd_drv  : 'z;
  assign c1_data = data_oe ? data_drv : 'z;

  always #5 clk = ~clk;

  c1_bus_arbiter #(
    .MEM_ADDR_SIZE     (AS),
    .CACHE_OFFSET_SIZE (OS),
    .BUS_SIZE          (BS),
    .TIMEOUT_CYCLES    (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_cmd   (req_cmd),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .c1_addr   (c1_addr),
    .c1_data   (c1_data),
    .c1_cmd    (c1_cmd)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_rel(input string tag);
    chk({tag, "_addr_rel"}, 32'(c1_addr), 32'h7FFF);
    chk({tag, "_data_rel"}, 32'(c1_data), 32'hFFFF);
    chk({tag, "_cmd_rel"},  32'(c1_cmd),  32'h0);
  endtask

  typedef struct {
    int          r;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t sb_e;

  always @(negedge clk) begin
    if (!reset && rsp_valid != 2'b00) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_valid), 32'h0);
      end else begin
        sb_e = sb.pop_front();
        chk("rsp_owner", 32'(rsp_valid), 32'(2'b01 << sb_e.r));
        chk("rsp_rdata", rsp_rdata, sb_e.rdata);
        chk("rsp_err",   32'(rsp_err), 32'(sb_e.err));
      end
    end
  end

  // Samples #1 after the negedge so a grant raised at this negedge is seen.
  task automatic wait_grant(input logic [1:0] mask, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if ((req_ready & mask) != 2'b00) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("grant_seen", 32'(ok), 32'h1);
  endtask

  // Entered in the grant cycle; dly < 0 means the cache never answers.
  task automatic run_bus(input int r, input logic [2:0] cmd, input logic [AS-1:0] addr,
                         input logic [31:0] wd, input int dly, input logic [15:0] lo,
                         input logic [15:0] hi, input bit drop);
    exp_t        e;
    logic        rd, wr;
    logic [15:0] wdat;
    rd = (cmd == C1_READ8) || (cmd == C1_READ16) || (cmd == C1_READ32);
    wr = (cmd == C1_WRITE8) || (cmd == C1_WRITE16) || (cmd == C1_WRITE32);
    e.r     = r;
    e.err   = (cmd == C1_NOP) || (dly < 0);
    e.rdata = 32'h0;
    if (dly >= 0 && cmd == C1_READ32) e.rdata = {hi, lo};
    else if (dly >= 0 && rd)          e.rdata = {16'h0, lo};
    sb.push_back(e);

    @(negedge clk);
    if (drop) req_valid = '0;
    if (cmd == C1_NOP) begin
      chk("nop_rsp_valid", 32'(rsp_valid[r]), 32'h1);
      chk_rel("nop");
      return;
    end
    chk("a1_cmd",  32'(c1_cmd),  32'(cmd));
    chk("a1_addr", 32'(c1_addr), 32'(addr[AS-1:OS]));
    chk("a1_data", 32'(c1_data), wr ? 32'(wd[15:0]) : 32'hFFFF);

    @(negedge clk);
    wdat = (cmd == C1_WRITE32) ? wd[31:16] : wd[15:0];
    chk("a2_cmd",  32'(c1_cmd),  32'(cmd));
    chk("a2_addr", 32'(c1_addr), 32'(addr[OS-1:0]));
    chk("a2_data", 32'(c1_data), wr ? 32'(wdat) : 32'hFFFF);

    for (int k = 0; k < TO; k++) begin
      @(negedge clk);
      chk("w_addr", 32'(c1_addr), 32'h7FFF);
      chk("w_data", 32'(c1_data), wr ? 32'(wdat) : 32'hFFFF);
      chk("w_cmd",  32'(c1_cmd),  32'h0);
      chk("w_rspv", 32'(rsp_valid), 32'h0);
      if (k == dly) begin
        cmd_oe  = 1'b1;
        cmd_drv = C1_RESPONSE;
        if (!wr) begin
          data_oe  = 1'b1;
          data_drv = lo;
        end
        break;
      end
    end

    @(negedge clk);
    if (dly < 0) begin
      chk("to_rsp_valid", 32'(rsp_valid[r]), 32'h1);
      chk_rel("to");
      return;
    end
    if (cmd == C1_READ32) begin
      chk("rdhi_rspv", 32'(rsp_valid), 32'h0);
      cmd_oe   = 1'b0;
      data_drv = hi;
      @(negedge clk);
    end
    chk("rsp_timing", 32'(rsp_valid[r]), 32'h1);
    chk("done_addr_rel", 32'(c1_addr), 32'h7FFF);
    if (wr) chk("wr_data_rel", 32'(c1_data), 32'hFFFF);
    cmd_oe  = 1'b0;
    data_oe = 1'b0;
  endtask

  task automatic txn(input int r, input logic [2:0] cmd, input logic [AS-1:0] addr,
                     input logic [31:0] wd, input int dly, input logic [15:0] lo,
                     input logic [15:0] hi);
    bit ok;
    @(negedge clk);
    req_valid    = '0;
    req_valid[r] = 1'b1;
    req_cmd[r]   = cmd;
    req_addr[r]  = addr;
    req_wdata[r] = wd;
    wait_grant(2'b01 << r, ok);
    if (ok) run_bus(r, cmd, addr, wd, dly, lo, hi, 1'b1);
    else    req_valid = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    req_valid = '0;
    cmd_oe    = 1'b0;
    data_oe   = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int g;
    reset     = 1'b1;
    req_valid = '0;
    req_cmd   = '0;
    req_addr  = '0;
    req_wdata = '0;
    cmd_oe    = 1'b0;
    data_oe   = 1'b0;
    cmd_drv   = '0;
    data_drv  = '0;

    do_reset();
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err",   32'(rsp_err), 32'h0);
    chk_rel("rst");

    // Both requesters pending every cycle: r0 first after reset, then alternate.
    req_cmd[0] = C1_READ8;  req_addr[0] = 19'h00100; req_wdata[0] = '0;
    req_cmd[1] = C1_READ16; req_addr[1] = 19'h00204; req_wdata[1] = '0;
    req_valid  = 2'b11;
    for (int t = 0; t < 4; t++) begin
      wait_grant(2'b11, ok);
      chk("rr_grant", 32'(req_ready), (t % 2) ? 32'h2 : 32'h1);
      if (!ok) break;
      g = req_ready[1] ? 1 : 0;
      run_bus(g, req_cmd[g], req_addr[g], req_wdata[g], 1, 16'h0A00 + 16'(t), 16'h0, t == 3);
    end
    req_valid = '0;

    txn(0, C1_READ8,    19'h001E0, 32'h0,        5,  16'h00F0, 16'h0);
    txn(1, C1_WRITE32,  19'h12344, 32'h5555AAAA, 3,  16'h0,    16'h0);
    txn(0, C1_READ32,   19'h0ABC8, 32'h0,        2,  16'h1234, 16'h5678);
    txn(0, C1_WRITE8,   19'h7FFFF, 32'hDEAD00C3, 0,  16'h0,    16'h0);
    txn(1, C1_INV_LINE, 19'h04440, 32'h0,        4,  16'h0,    16'h0);
    txn(0, C1_READ16,   19'h00038, 32'h0,        -1, 16'h0,    16'h0);
    txn(1, C1_NOP,      19'h00010, 32'h0,        0,  16'h0,    16'h0);
    txn(0, C1_READ16,   19'h0003C, 32'h0,        TO - 1, 16'h8001, 16'h0);

    // Reset while waiting on the cache: bus released, no completion.
    @(negedge clk);
    req_valid[0] = 1'b1; req_cmd[0] = C1_READ8; req_addr[0] = 19'h00310;
    wait_grant(2'b01, ok);
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
    chk("abort_in_wait_addr", 32'(c1_addr), 32'h7FFF);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_req_ready", 32'(req_ready), 32'h0);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("abort_rsp_rdata", rsp_rdata, 32'h0);
    chk("abort_rsp_err",   32'(rsp_err), 32'h0);
    chk_rel("abort");
    reset = 1'b0;
    repeat (3) @(negedge clk);

    txn(1, C1_READ32, 19'h01230, 32'h0, 2, 16'hBEEF, 16'hCAFE);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
